// File: rtl/seq_mult_pkg.sv
// Shared types and limits for the shift-add sequential multiplier.
package seq_mult_pkg;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mult_adder.sv
// WIDTH-bit adder with carry-out used by the multiplier datapath for each step.
module seq_mult_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier: WIDTH steps per product, done pulses one cycle later.
// Optional two's complement mode is enabled by defining SEQ_MULT_SIGNED_EN.
module seq_multiplier
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
`ifdef SEQ_MULT_SIGNED_EN
  input  logic               signed_mode,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output state_t             o_dbg_state
);

  // Handshake: start is a request level sampled on each rising edge; it is
  // accepted only in IDLE or DONE (operands latched on that same edge) and is
  // ignored in RUN. done is a one-cycle pulse with product valid in that cycle.

  localparam int             CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_product;
  logic               r_busy;
  logic               r_done;

  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH-1:0]   w_sum;
  logic               w_cout;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [2*WIDTH-1:0] w_result;
  logic [WIDTH-1:0]   w_a_op;
  logic [WIDTH-1:0]   w_b_op;

  assign w_addend = r_acc[0] ? r_mcand : '0;

  seq_mult_adder #(.WIDTH(WIDTH)) u_adder (
    .a    (r_acc[2*WIDTH-1:WIDTH]),
    .b    (w_addend),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // Upper half accumulates, lower half holds the remaining multiplier bits.
  assign w_acc_next = {w_cout, w_sum, r_acc[WIDTH-1:1]};

`ifdef SEQ_MULT_SIGNED_EN
  logic r_neg;

  assign w_a_op   = (signed_mode && a_in[WIDTH-1]) ? -a_in : a_in;
  assign w_b_op   = (signed_mode && b_in[WIDTH-1]) ? -b_in : b_in;
  assign w_result = r_neg ? -w_acc_next : w_acc_next;
`else
  assign w_a_op   = a_in;
  assign w_b_op   = b_in;
  assign w_result = w_acc_next;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_product <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
      r_neg     <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state <= RUN;
            r_cnt   <= '0;
            r_acc   <= {{WIDTH{1'b0}}, w_b_op};
            r_mcand <= w_a_op;
            r_busy  <= 1'b1;
`ifdef SEQ_MULT_SIGNED_EN
            r_neg   <= signed_mode && (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
`endif
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        RUN: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_state   <= DONE;
            r_product <= w_result;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign product     = r_product;
  assign o_dbg_state = r_state;

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, giving the operand width in bits; legal values are 2 to 32.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port start, input, 1 bit: request to begin a multiply.
REQ-005 The module SHALL have port a_in, input, WIDTH bits: multiplicand, sampled when start is accepted.
REQ-006 The module SHALL have port b_in, input, WIDTH bits: multiplier, sampled when start is accepted.
REQ-007 The module SHALL have port busy, output, 1 bit: high while an iteration sequence is in progress.
REQ-008 The module SHALL have port done, output, 1 bit: one-cycle pulse when product becomes valid.
REQ-009 The module SHALL have port product, output, 2*WIDTH bits: registered result, held until the next completion.

Function
REQ-010 The FSM SHALL have states IDLE, RUN and DONE.
REQ-011 In IDLE or DONE, start=1 SHALL be accepted on the clock edge: a_in and b_in are latched, the accumulator and the step counter are cleared, and the FSM enters RUN.
REQ-012 In RUN, each edge SHALL perform one shift-add step: if multiplier LSB=1, add the multiplicand to the upper accumulator half using a WIDTH-bit add with carry-out; shift {carry, sum, multiplier} right by 1; increment the counter.
REQ-013 After the WIDTH-th RUN step, the FSM SHALL enter DONE and load product with the final accumulator.
REQ-014 Latency SHALL be fixed: start accepted at edge k gives done=1 and a valid product during the cycle after edge k+WIDTH.
REQ-015 busy SHALL equal (state==RUN); done SHALL equal (state==DONE).
REQ-016 From DONE without start, the FSM SHALL return to IDLE; product SHALL hold its value.
REQ-017 start SHALL be ignored while in RUN; a_in and b_in SHALL have no effect outside the accepting edge.
REQ-018 Unsigned arithmetic SHALL be exact for all operands, and no overflow is possible: (2^W-1)^2 fits in 2W bits.

Reset
REQ-019 When reset=0, the block SHALL asynchronously force state=IDLE, counter=0, accumulator=0, product=0, busy=0 and done=0.
REQ-020 A reset asserted mid-RUN SHALL abort the operation with no done pulse; the first start after release SHALL behave normally.

Configuration
REQ-021 With macro SEQ_MULT_SIGNED_EN defined, the block SHALL add input port signed_mode (1 bit, sampled with the operands).
REQ-022 With SEQ_MULT_SIGNED_EN defined and signed_mode=1, the block SHALL treat the operands as two's complement: latch their magnitudes, run the unsigned sequence, and negate the 2W-bit result when loading product if the operand signs differ; latency is unchanged.
REQ-023 Without SEQ_MULT_SIGNED_EN, the signed_mode port and all sign logic SHALL be absent, and the block SHALL be unsigned only.

Structure
REQ-024 Package seq_mult_pkg SHALL hold the state typedef (IDLE/RUN/DONE) and the WIDTH bounds constants.
REQ-025 The WIDTH-bit add SHALL be one sub-module, seq_mult_adder (parameter WIDTH; a, b, sum, cout), instantiated once.

Verification
REQ-026 The bench SHALL check WIDTH=4: a=15, b=15, start pulse -> done exactly 5 cycles after the accepting edge, product=225, busy high for 4 cycles.
REQ-027 The bench SHALL check WIDTH=4: a=0, b=9 -> product=0; then a=9, b=0 -> product=0; product held between runs.
REQ-028 The bench SHALL check start held high continuously with a=3, b=5 then a=6, b=7 -> products 15 and 42 in back-to-back runs, start ignored during RUN.
REQ-029 The bench SHALL check reset dropped at RUN step 2 of a=7, b=7 -> busy=0, done never pulses, product=0; the next run a=2, b=3 -> product=6.
REQ-030 The bench SHALL check, with SEQ_MULT_SIGNED_EN, WIDTH=4, signed_mode=1: -8*-8 -> 64; -8*7 -> -56 (8'hC8); -1*1 -> 8'hFF; signed_mode=0, 4'h8*4'h8 -> 64.
REQ-031 The bench SHALL check WIDTH=8 random unsigned pairs (at least 1000) against a reference model with fixed latency 9.
